// File: rtl/mmu_load_ctrl.sv
// MMU operand loader: captures 4 weights + 4 inputs, then sequences a feeder pass (optional WEIGHT_REUSE_EN keeps weights).
// Latency: en 1 cycle after 8th byte, done LAST_CYCLE+2 cycles after it; in_ready low (backpressure) outside LOAD.
module mmu_load_ctrl #(
    parameter int DATA_W     = 8,
    parameter int LAST_CYCLE = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] weight_0,
    output logic [DATA_W-1:0] weight_1,
    output logic [DATA_W-1:0] weight_2,
    output logic [DATA_W-1:0] weight_3,
    output logic [DATA_W-1:0] input_0,
    output logic [DATA_W-1:0] input_1,
    output logic [DATA_W-1:0] input_2,
    output logic [DATA_W-1:0] input_3,
    output logic              en,
    output logic              clear,
    output logic [2:0]        mmu_cycles,
    output logic              busy,
`ifdef WEIGHT_REUSE_EN
    input  logic              keep_weights,
`endif
    output logic              done
);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE} state_t;

    localparam logic [2:0] LAST_C = 3'(LAST_CYCLE);

    state_t                  state_q, state_d;
    logic [2:0]              load_idx_q, load_idx_d;
    logic [2:0]              mmu_cycles_q, mmu_cycles_d;
    logic [7:0][DATA_W-1:0]  ops_q, ops_d;
    logic                    en_q, en_d, clear_q, clear_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic                    accept;
    logic [2:0]              restart_idx;

    assign accept = in_valid && (state_q == S_LOAD);

`ifdef WEIGHT_REUSE_EN
    // Reusing weights means the next load starts at input_0.
    assign restart_idx = keep_weights ? 3'd4 : 3'd0;
`else
    assign restart_idx = 3'd0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_LOAD;
            load_idx_q   <= 3'd0;
            mmu_cycles_q <= 3'd0;
            ops_q        <= '0;
            en_q         <= 1'b0;
            clear_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_idx_q   <= load_idx_d;
            mmu_cycles_q <= mmu_cycles_d;
            ops_q        <= ops_d;
            en_q         <= en_d;
            clear_q      <= clear_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_idx_d   = load_idx_q;
        mmu_cycles_d = mmu_cycles_q;
        ops_d        = ops_q;
        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    ops_d[load_idx_q] = in_data;
                    if (load_idx_q == 3'd7) begin
                        state_d      = S_RUN;
                        load_idx_d   = 3'd0;
                        mmu_cycles_d = 3'd0;
                    end else begin
                        load_idx_d = load_idx_q + 3'd1;
                    end
                end
            end
            S_RUN: begin
                if (mmu_cycles_q == LAST_C) begin
                    state_d      = S_DONE;
                    mmu_cycles_d = 3'd0;
                end else begin
                    mmu_cycles_d = mmu_cycles_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d    = S_LOAD;
                load_idx_d = restart_idx;
            end
            default: state_d = S_LOAD;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with state_q.
    always_comb begin
        in_ready = (state_q == S_LOAD);
        en_d     = (state_d == S_RUN);
        clear_d  = !en_d;
        busy_d   = en_d;
        done_d   = (state_d == S_DONE);
    end

    assign weight_0   = ops_q[0];
    assign weight_1   = ops_q[1];
    assign weight_2   = ops_q[2];
    assign weight_3   = ops_q[3];
    assign input_0    = ops_q[4];
    assign input_1    = ops_q[5];
    assign input_2    = ops_q[6];
    assign input_3    = ops_q[7];
    assign en         = en_q;
    assign clear      = clear_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign mmu_cycles = mmu_cycles_q;

endmodule
